// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit control codes used by the ALU-control decoder and the execute unit,
// plus the execute-unit FSM state encoding.
// Latency: n/a (constants and types only). Backpressure: n/a.
package alu_pkg;

    // ALU control codes produced by the ALU-control decoder
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_INV = 4'b1111;

    // Execute-unit sequencing state; BUSY only exists while an iterative multiply runs
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle, low WIDTH bits of the product.
// Latency: start in cycle N, done asserted (with product valid) in cycle N+WIDTH.
// Backpressure: none; the caller must be able to take the product in the done cycle.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_next;

    // Partial-product update for the current multiplier bit
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    // The last iteration's sum is handed out directly so the caller can register it in the done cycle
    assign done    = busy && (cnt == CW'(WIDTH - 1));
    assign product = acc_next;

    // Iteration state: load operands on start, then shift one bit per cycle until the count expires
    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU between ID/EX and EX/MEM; optional iterative multiply enabled by macro ALU_MUL_EN.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for multiply (unit busy meanwhile).
// Backpressure: in_ready drops while a result is stalled (out_valid && !out_ready) or a multiply runs.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    logic             in_fire;
    logic             out_fire;
    logic             load_single;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    logic             alu_ovf;
    logic             alu_ill;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Single-cycle datapath; unsupported codes flag illegal with a zero result
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (ctrl)
            ALU_ADD: begin
                alu_res = op_a + op_b;
                alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = op_a - op_b;
                alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_NOR: alu_res = ~(op_a | op_b);
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef ALU_MUL_EN
            // Handled by the sequential multiplier; this path is not loaded for it
            ALU_MUL: alu_res = '0;
`endif
            default: alu_ill = 1'b1;
        endcase
        alu_zero = !alu_ill && (alu_res == '0);
    end

`ifdef ALU_MUL_EN
    alu_state_e       state;
    alu_state_e       state_nxt;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    assign mul_start   = in_fire && (ctrl == ALU_MUL);
    assign load_single = in_fire && (ctrl != ALU_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a multiply occupies the unit until the multiplier reports done
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mul_start) state_nxt = ST_BUSY;
            ST_BUSY: if (mul_done)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: accept only when idle and the output register is empty or draining
    always_comb begin
        in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    end
`else
    assign load_single = in_fire;

    // Accept whenever the output register is empty or draining this cycle
    always_comb begin
        in_ready = !out_valid || out_ready;
    end
`endif

    // Output register: loads from the single-cycle path or the multiplier, clears when drained.
    // A multiply is only accepted once the previous result has fired, so the done load never collides.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (load_single) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            zero      <= alu_zero;
            overflow  <= alu_ovf;
            illegal   <= alu_ill;
`ifdef ALU_MUL_EN
        end else if (mul_done) begin
            out_valid <= 1'b1;
            result    <= mul_prod;
            zero      <= (mul_prod == '0);
            overflow  <= 1'b0;
            illegal   <= 1'b0;
`endif
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases plus randomized traffic with random backpressure,
// scored against a signed/unsigned arithmetic reference model and an in-order result queue.
// Build with ALU_MUL_EN defined to exercise the multiply path.
module tb_alu_exec_unit;

    localparam int W = 32;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W - 1));

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         ov;
        logic         ill;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   ctrl = 4'b0000;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         illegal;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: arithmetic on wide integers, flags derived from range checks
    function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa;
        longint sb;
        longint s;
        longint unsigned p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.r = '0; e.ov = 1'b0; e.ill = 1'b0; e.lat = 1; e.acc = 0;
        case (c)
            4'b0010: begin s = sa + sb; e.r = s[W-1:0]; e.ov = (s > SMAX) || (s < SMIN); end
            4'b0110: begin s = sa - sb; e.r = s[W-1:0]; e.ov = (s > SMAX) || (s < SMIN); end
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b1100: e.r = ~(a | b);
            4'b0111: e.r = (sa < sb) ? 1 : 0;
`ifdef ALU_MUL_EN
            4'b1000: begin p = {32'b0, a} * {32'b0, b}; e.r = p[W-1:0]; e.lat = W + 1; end
`endif
            default: e.ill = 1'b1;
        endcase
        e.z = !e.ill && (e.r == 0);
        return e;
    endfunction

    // Monitor / scoreboard: sampled on the falling edge, away from the active edge
    exp_t q[$];
    logic prev_hold = 1'b0;
    int   busy_until = -1;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            q.delete();
            busy_until = -1;
            prev_hold = 1'b0;
        end else begin
            check("in_ready", in_ready, (cyc > busy_until) && (!out_valid || out_ready));
            if (prev_hold) check("hold_valid", out_valid, 1'b1);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", out_valid, 1'b0);
                end else begin
                    if (!prev_hold) check("latency", cyc - q[0].acc, q[0].lat);
                    check("result", result, q[0].r);
                    check("zero", zero, q[0].z);
                    check("overflow", overflow, q[0].ov);
                    check("illegal", illegal, q[0].ill);
                end
            end else if (q.size() > 0 && (cyc - q[0].acc) > q[0].lat) begin
                check("late_valid", out_valid, 1'b1);
            end
            prev_hold = out_valid && !out_ready;
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                e = model(ctrl, op_a, op_b);
                e.acc = cyc;
                q.push_back(e);
                if (e.lat > 1) busy_until = cyc + W;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one op and hold it until accepted; returns 1 time unit after the accepting edge
    task automatic send(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        logic rdy;
        int n;
        n = 0;
        ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) check("send_timeout", rdy, 1'b1);
        in_valid = 1'b0;
    endtask

    // Single-cycle op with out_ready=1: result must be on the outputs in the very next cycle
    task automatic send_see(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] er, input logic [2:0] ef);
        send(c, a, b);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_result"}, result, er);
        check({tag, "_flags"}, {zero, overflow, illegal}, ef);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick_op();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return W'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    logic [3:0] codes [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100, 4'b1000};
    logic       rand_phase = 1'b0;

    initial begin
        int k;
        logic seen;
        logic [W-1:0] res_seen;
        logic [3:0] c;

        idle(2);
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 0);
        check("rst_flags", {zero, overflow, illegal}, 3'b000);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        send_see("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 3'b010);
        send_see("sub_zero", 4'b0110, 32'd5, 32'd5, 32'h0, 3'b100);
        send_see("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 3'b000);
        send_see("slt_swap", 4'b0111, 32'h1, 32'hFFFF_FFFF, 32'h0, 3'b100);

        // Illegal code, then stall the output for 3 cycles
        out_ready = 1'b0;
        send(4'b1111, 32'd3, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_valid", out_valid, 1'b1);
            check("stall_result", result, 0);
            check("stall_flags", {zero, overflow, illegal}, 3'b001);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        idle(2);

        // Back-to-back: monitor checks order and 1-cycle latency for each
        send(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF);
        send(4'b0001, 32'hF000_0000, 32'h0000_000F);
        send(4'b1100, 32'h0000_FFFF, 32'hFF00_0000);
        send(4'b0010, 32'd100, 32'hFFFF_FF9C);
        idle(3);

`ifdef ALU_MUL_EN
        send(4'b1000, 32'd6, 32'd7);
        k = 0; seen = 1'b0; res_seen = '0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (out_valid) begin
                seen = 1'b1;
                res_seen = result;
            end else begin
                check("mul_in_ready", in_ready, 1'b0);
            end
            @(posedge clk);
            #1;
        end
        check("mul_latency", k, W + 1);
        check("mul_result", res_seen, 42);
        idle(2);

        // Reset in cycle 10 of a multiply: nothing may come out
        send(4'b1000, 32'd9, 32'd9);
        idle(9);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mulrst_in_ready", in_ready, 1'b1);
        check("mulrst_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        idle(40);
`else
        send_see("mul_illegal", 4'b1000, 32'd6, 32'd7, 32'h0, 3'b001);
`endif

        // Randomized traffic with random output backpressure
        rand_phase = 1'b1;
        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    if ($urandom_range(0, 9) == 0) c = 4'($urandom_range(0, 15));
                    else c = codes[$urandom_range(0, 6)];
                    send(c, pick_op(), pick_op());
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                rand_phase = 1'b0;
            end
            begin
                while (rand_phase) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join

        k = 0;
        while (q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
